// File: rtl/llc_bus_snoop_agent.sv
// LLC-side bus agent: issues one bus operation at a time, merges peer snoop
// responses (HITM > HIT > NOHIT) within a bounded window and keeps op statistics.
module llc_bus_snoop_agent #(
    parameter int ADDR_W        = 32,
    parameter int NUM_SNOOPERS  = 3,
    parameter int SNOOP_TIMEOUT = 8,
    parameter int CNT_W         = 32,
    parameter int EMULATE_SNOOP = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [ADDR_W-1:0]         req_addr,
    output logic                      bus_valid,
    output logic [2:0]                bus_op,
    output logic [ADDR_W-1:0]         bus_addr,
    input  logic [NUM_SNOOPERS-1:0]   snoop_valid,
    input  logic [2*NUM_SNOOPERS-1:0] snoop_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2:0]                rsp_op,
    output logic [1:0]                rsp_result,
    output logic                      rsp_timeout,
    output logic                      err_illegal,
    output logic [CNT_W-1:0]          rd_count,
    output logic [CNT_W-1:0]          wr_count,
    output logic [CNT_W-1:0]          inv_count,
    output logic [CNT_W-1:0]          tmo_count
);

    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_INV   = 3'b011;
    localparam logic [2:0] OP_RWIM  = 3'b100;
    localparam int TMR_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SNOOP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, SNOOP, RESP} state_t;

    state_t                  state;
    logic [2:0]              op_q;
    logic [NUM_SNOOPERS-1:0] mask;
    logic [NUM_SNOOPERS-1:0] mask_next;
    logic [1:0]              merged;
    logic [1:0]              merged_next;
    logic [TMR_W-1:0]        timer;
    logic [1:0]              emu_result;
    logic                    accept;
    logic                    legal_op;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign legal_op  = (req_op == OP_READ) || (req_op == OP_WRITE) ||
                       (req_op == OP_INV)  || (req_op == OP_RWIM);

    // Result codes are ordered by priority, so merging is a numeric max once
    // the reserved code 11 is folded to NOHIT. Only first strobes count.
    always_comb begin
        merged_next = merged;
        for (int i = 0; i < NUM_SNOOPERS; i++) begin
            if (snoop_valid[i] && !mask[i] && snoop_result[2*i +: 2] != 2'b11 &&
                snoop_result[2*i +: 2] > merged_next)
                merged_next = snoop_result[2*i +: 2];
        end
        mask_next = mask | snoop_valid;
    end

    // bus_addr holds the captured address for the whole operation.
    assign emu_result = (bus_addr[1:0] == 2'b00) ? 2'b01 :
                        (bus_addr[1:0] == 2'b01) ? 2'b10 : 2'b00;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            mask        <= '0;
            merged      <= '0;
            timer       <= '0;
            bus_valid   <= 1'b0;
            bus_op      <= '0;
            bus_addr    <= '0;
            rsp_valid   <= 1'b0;
            rsp_op      <= '0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
            err_illegal <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
            inv_count   <= '0;
            tmo_count   <= '0;
        end else begin
            bus_valid   <= 1'b0;
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && legal_op) begin
                        op_q      <= req_op;
                        bus_valid <= 1'b1;
                        bus_op    <= req_op;
                        bus_addr  <= req_addr;
                        state     <= ISSUE;
                        case (req_op)
                            OP_WRITE: wr_count  <= sat_inc(wr_count);
                            OP_INV:   inv_count <= sat_inc(inv_count);
                            default:  rd_count  <= sat_inc(rd_count);
                        endcase
                    end else if (accept) begin
                        err_illegal <= 1'b1;
                    end
                end
                ISSUE: begin
                    mask   <= '0;
                    merged <= '0;
                    timer  <= '0;
                    rsp_op <= op_q;
                    if (op_q == OP_WRITE) begin
                        rsp_valid   <= 1'b1;
                        rsp_result  <= 2'b00;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else begin
                        state <= SNOOP;
                    end
                end
                SNOOP: begin
                    if (EMULATE_SNOOP != 0) begin
                        rsp_valid   <= 1'b1;
                        rsp_result  <= emu_result;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else begin
                        mask   <= mask_next;
                        merged <= merged_next;
                        timer  <= timer + 1'b1;
                        // Completion wins over a timeout landing on the same cycle.
                        if (&mask_next) begin
                            rsp_valid   <= 1'b1;
                            rsp_result  <= merged_next;
                            rsp_timeout <= 1'b0;
                            state       <= RESP;
                        end else if (timer == TMR_LAST) begin
                            rsp_valid   <= 1'b1;
                            rsp_result  <= merged_next;
                            rsp_timeout <= 1'b1;
                            tmo_count   <= sat_inc(tmo_count);
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_bus_snoop_agent.sv
// Randomized bench for llc_bus_snoop_agent: a transaction-level model predicts
// every cycle's outputs; a second instance exercises the address-emulated snoop mode.
module tb_llc_bus_snoop_agent;

    localparam int T  = 8;
    localparam int NS = 3;
    localparam int CW = 4;
    localparam int ECW = 8;
    localparam logic [2:0] RD = 3'b001, WR = 3'b010, INV = 3'b011, RWIM = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0, req_ready;
    logic [2:0]      req_op = '0;
    logic [31:0]     req_addr = '0;
    logic            bus_valid;
    logic [2:0]      bus_op;
    logic [31:0]     bus_addr;
    logic [NS-1:0]   snoop_valid = '0;
    logic [2*NS-1:0] snoop_result = '0;
    logic            rsp_valid, rsp_ready = 1'b0;
    logic [2:0]      rsp_op;
    logic [1:0]      rsp_result;
    logic            rsp_timeout, err_illegal;
    logic [CW-1:0]   rd_count, wr_count, inv_count, tmo_count;

    logic            em_req_valid = 1'b0, em_req_ready;
    logic [2:0]      em_req_op = '0;
    logic [31:0]     em_req_addr = '0;
    logic            em_bus_valid;
    logic [2:0]      em_bus_op;
    logic [31:0]     em_bus_addr;
    logic [NS-1:0]   em_snoop_valid = '0;
    logic [2*NS-1:0] em_snoop_result = '0;
    logic            em_rsp_valid, em_rsp_ready = 1'b1;
    logic [2:0]      em_rsp_op;
    logic [1:0]      em_rsp_result;
    logic            em_rsp_timeout, em_err_illegal;
    logic [ECW-1:0]  em_rd_count, em_wr_count, em_inv_count, em_tmo_count;

    llc_bus_snoop_agent #(.ADDR_W(32), .NUM_SNOOPERS(NS), .SNOOP_TIMEOUT(T),
                          .CNT_W(CW), .EMULATE_SNOOP(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .bus_valid(bus_valid), .bus_op(bus_op),
        .bus_addr(bus_addr), .snoop_valid(snoop_valid), .snoop_result(snoop_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .err_illegal(err_illegal),
        .rd_count(rd_count), .wr_count(wr_count), .inv_count(inv_count),
        .tmo_count(tmo_count));

    llc_bus_snoop_agent #(.ADDR_W(32), .NUM_SNOOPERS(NS), .SNOOP_TIMEOUT(T),
                          .CNT_W(ECW), .EMULATE_SNOOP(1)) dut_emu (
        .clk(clk), .rst(rst), .req_valid(em_req_valid), .req_ready(em_req_ready),
        .req_op(em_req_op), .req_addr(em_req_addr), .bus_valid(em_bus_valid),
        .bus_op(em_bus_op), .bus_addr(em_bus_addr), .snoop_valid(em_snoop_valid),
        .snoop_result(em_snoop_result), .rsp_valid(em_rsp_valid),
        .rsp_ready(em_rsp_ready), .rsp_op(em_rsp_op), .rsp_result(em_rsp_result),
        .rsp_timeout(em_rsp_timeout), .err_illegal(em_err_illegal),
        .rd_count(em_rd_count), .wr_count(em_wr_count), .inv_count(em_inv_count),
        .tmo_count(em_tmo_count));

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: counters, last issued bus op/addr.
    int m_rd = 0, m_wr = 0, m_inv = 0, m_tmo = 0;
    logic [2:0]  m_bop = '0;
    logic [31:0] m_baddr = '0;

    function automatic int sat(input int c);
        return (c < (1 << CW) - 1) ? c + 1 : c;
    endfunction

    // Per-cycle expectations, checked at every falling edge while chk_en.
    bit            chk_en = 1'b0;
    logic          x_req_ready, x_bus_valid, x_rsp_valid, x_rsp_timeout, x_err;
    logic [2:0]    x_bus_op, x_rsp_op;
    logic [31:0]   x_bus_addr;
    logic [1:0]    x_rsp_result;
    logic [CW-1:0] x_rd, x_wr, x_inv, x_tmo;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, x_req_ready);
            chk("bus_valid", bus_valid, x_bus_valid);
            chk("bus_op", bus_op, x_bus_op);
            chk("bus_addr", bus_addr, x_bus_addr);
            chk("rsp_valid", rsp_valid, x_rsp_valid);
            chk("err_illegal", err_illegal, x_err);
            if (x_rsp_valid) begin
                chk("rsp_op", rsp_op, x_rsp_op);
                chk("rsp_result", rsp_result, x_rsp_result);
                chk("rsp_timeout", rsp_timeout, x_rsp_timeout);
            end
            chk("rd_count", rd_count, x_rd);
            chk("wr_count", wr_count, x_wr);
            chk("inv_count", inv_count, x_inv);
            chk("tmo_count", tmo_count, x_tmo);
        end
    end

    // Snoop strobe schedule, indexed by cycle offset from request acceptance.
    logic [NS-1:0]   sv_tab [0:15];
    logic [2*NS-1:0] sr_tab [0:15];

    task automatic clear_sched();
        for (int k = 0; k < 16; k++) begin
            sv_tab[k] = '0;
            sr_tab[k] = '0;
        end
    endtask

    task automatic rand_sched(input int pct);
        logic [NS-1:0] silent;
        for (int i = 0; i < NS; i++) silent[i] = ($urandom_range(0, 5) == 0);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NS; i++)
                sv_tab[k][i] = !silent[i] && ($urandom_range(0, 99) < pct);
            sr_tab[k] = (2*NS)'($urandom);
        end
    endtask

    task automatic set_idle_exp();
        x_req_ready = 1'b1; x_bus_valid = 1'b0; x_bus_op = m_bop; x_bus_addr = m_baddr;
        x_rsp_valid = 1'b0; x_rsp_op = '0; x_rsp_result = '0; x_rsp_timeout = 1'b0;
        x_err = 1'b0;
        x_rd = CW'(m_rd); x_wr = CW'(m_wr); x_inv = CW'(m_inv); x_tmo = CW'(m_tmo);
    endtask

    // One legal operation, request presented at offset 0 while idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input int dly,
                          output int r_o, output logic [1:0] res_o, output bit tmo_o);
        int first [NS];
        int r, h, last, n_rd, n_wr, n_inv, n_tmo;
        logic [1:0] res, c;
        bit tmo, all;
        res = 2'b00; tmo = 1'b0;
        if (op == WR) begin
            r = 2;
        end else begin
            // Snoop window covers offsets 2 .. T+1; only first in-window strobes count.
            all = 1'b1; last = 0;
            for (int i = 0; i < NS; i++) begin
                first[i] = -1;
                for (int k = 2; k <= T + 1; k++)
                    if (first[i] < 0 && sv_tab[k][i]) first[i] = k;
                if (first[i] < 0) all = 1'b0;
                else begin
                    c = sr_tab[first[i]][2*i +: 2];
                    if (c != 2'b11 && c > res) res = c;
                    if (first[i] > last) last = first[i];
                end
            end
            if (all) r = last + 1;
            else begin r = T + 2; tmo = 1'b1; end
        end
        h = r + dly;
        n_rd  = (op == RD || op == RWIM) ? sat(m_rd) : m_rd;
        n_wr  = (op == WR)  ? sat(m_wr)  : m_wr;
        n_inv = (op == INV) ? sat(m_inv) : m_inv;
        n_tmo = tmo ? sat(m_tmo) : m_tmo;
        for (int k = 0; k <= h + 1; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                req_valid = 1'b1; req_op = op; req_addr = addr;
            end else if (k <= h) begin
                req_valid = 1'($urandom_range(0, 1)); req_op = 3'($urandom); req_addr = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            snoop_valid  = (k < 16) ? sv_tab[k] : '0;
            snoop_result = (k < 16) ? sr_tab[k] : '0;
            rsp_ready = (k >= h) ? 1'b1 : (k < r) ? 1'($urandom_range(0, 1)) : 1'b0;
            x_req_ready   = (k == 0) || (k == h + 1);
            x_bus_valid   = (k == 1);
            x_bus_op      = (k >= 1) ? op : m_bop;
            x_bus_addr    = (k >= 1) ? addr : m_baddr;
            x_rsp_valid   = (k >= r) && (k <= h);
            x_rsp_op      = op;
            x_rsp_result  = res;
            x_rsp_timeout = tmo;
            x_err         = 1'b0;
            x_rd  = CW'((k >= 1) ? n_rd  : m_rd);
            x_wr  = CW'((k >= 1) ? n_wr  : m_wr);
            x_inv = CW'((k >= 1) ? n_inv : m_inv);
            x_tmo = CW'((k >= r) ? n_tmo : m_tmo);
        end
        m_rd = n_rd; m_wr = n_wr; m_inv = n_inv; m_tmo = n_tmo;
        m_bop = op; m_baddr = addr;
        r_o = r; res_o = res; tmo_o = tmo;
    endtask

    task automatic run_ill(input logic [2:0] op);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            req_valid = (k == 0); req_op = op; req_addr = $urandom;
            snoop_valid = NS'($urandom); snoop_result = (2*NS)'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            set_idle_exp();
            x_err = (k == 1);
        end
    endtask

    int em_n_rd = 0, em_n_wr = 0;

    task automatic emu_op(input logic [2:0] op, input logic [31:0] addr);
        int r;
        logic [1:0] exp;
        r = (op == WR) ? 2 : 3;
        if (op == WR) exp = 2'b00;
        else if (addr[1:0] == 2'b00) exp = 2'b01;
        else if (addr[1:0] == 2'b01) exp = 2'b10;
        else exp = 2'b00;
        for (int k = 0; k <= r + 1; k++) begin
            @(posedge clk); #1;
            em_req_valid = (k == 0); em_req_op = op; em_req_addr = addr;
            em_snoop_valid = NS'($urandom); em_snoop_result = (2*NS)'($urandom);
            em_rsp_ready = 1'b1;
            @(negedge clk);
            chk("emu_rsp_valid", em_rsp_valid, (k == r));
            if (k == r) begin
                chk("emu_rsp_result", em_rsp_result, exp);
                chk("emu_rsp_timeout", em_rsp_timeout, 1'b0);
                chk("emu_rsp_op", em_rsp_op, op);
            end
        end
        if (op == WR) em_n_wr++;
        else if (op == RD || op == RWIM) em_n_rd++;
    endtask

    initial begin
        int r;
        logic [1:0] res;
        bit tmo;
        logic [2:0] op;
        logic [2:0] legal [4];
        logic [2:0] illegal [4];
        legal = '{RD, WR, INV, RWIM};
        illegal = '{3'b000, 3'b101, 3'b110, 3'b111};
        clear_sched();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_bus_valid", bus_valid, 1'b0);
        chk("rst_bus_op", bus_op, 3'b000);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 2'b00);
        chk("rst_rsp_op", rsp_op, 3'b000);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_err", err_illegal, 1'b0);
        chk("rst_counts", {rd_count, wr_count, inv_count, tmo_count}, 16'h0);
        chk("rst_emu_rsp_valid", em_rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;

        // READ 0x1000, replies 00/01/00 at N+2.
        clear_sched(); sv_tab[2] = 3'b111; sr_tab[2] = 6'b00_01_00;
        run_op(RD, 32'h1000, 0, r, res, tmo);
        chk("pin_read_latency", r, 3);
        chk("pin_read_result", res, 2'b01);
        chk("read_rd_count", rd_count, 4'd1);

        // RWIM, HIT@N+2 (s0), HITM@N+4 (s1), NOHIT@N+5 (s2).
        clear_sched();
        sv_tab[2] = 3'b001; sr_tab[2] = 6'b00_00_01;
        sv_tab[4] = 3'b010; sr_tab[4] = 6'b00_10_00;
        sv_tab[5] = 3'b100; sr_tab[5] = 6'b00_00_00;
        run_op(RWIM, 32'h1040, 1, r, res, tmo);
        chk("pin_rwim_latency", r, 6);
        chk("pin_rwim_result", res, 2'b10);
        chk("rwim_rd_count", rd_count, 4'd2);

        // INVALIDATE, only snooper 0 answers: timeout.
        clear_sched(); sv_tab[2] = 3'b001; sr_tab[2] = 6'b00_00_01;
        run_op(INV, 32'h1080, 0, r, res, tmo);
        chk("pin_inv_latency", r, 10);
        chk("pin_inv_timeout", tmo, 1'b1);
        chk("pin_inv_result", res, 2'b01);
        chk("inv_tmo_count", tmo_count, 4'd1);

        // WRITE with consumer stalling 5 cycles.
        clear_sched();
        run_op(WR, 32'h2000, 5, r, res, tmo);
        chk("pin_write_latency", r, 2);
        chk("write_wr_count", wr_count, 4'd1);

        run_ill(3'b110);
        chk("ill_counts", {rd_count, wr_count, inv_count, tmo_count}, 16'h2111);

        // Reset while in SNOOP: operation dropped, everything back to reset values.
        chk_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            req_valid = (k == 0); req_op = RD; req_addr = 32'h3000;
            snoop_valid = (k == 2) ? 3'b001 : (k >= 5) ? 3'b111 : 3'b000;
            snoop_result = 6'b01_01_01;
            rst = (k == 3); rsp_ready = 1'b1;
            @(negedge clk);
            if (k == 3) chk("midrst_req_ready", req_ready, 1'b0);
            if (k == 4) begin
                chk("midrst_req_ready_after", req_ready, 1'b1);
                chk("midrst_bus_op", bus_op, 3'b000);
                chk("midrst_bus_addr", bus_addr, 32'h0);
                chk("midrst_counts", {rd_count, wr_count, inv_count, tmo_count}, 16'h0);
                chk("midrst_err", err_illegal, 1'b0);
            end
            if (k >= 4) chk("midrst_no_rsp", rsp_valid, 1'b0);
        end
        m_rd = 0; m_wr = 0; m_inv = 0; m_tmo = 0; m_bop = '0; m_baddr = '0;
        @(posedge clk); #1;
        set_idle_exp();
        chk_en = 1'b1;

        // Random mix; small counters saturate along the way.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_ill(illegal[$urandom_range(0, 3)]);
            end else begin
                op = legal[$urandom_range(0, 3)];
                case ($urandom_range(0, 2))
                    0: rand_sched(15);
                    1: rand_sched(40);
                    default: rand_sched(80);
                endcase
                run_op(op, $urandom, $urandom_range(0, 3), r, res, tmo);
            end
        end
        chk("sat_rd_count", rd_count, 4'hf);
        chk_en = 1'b0;

        emu_op(RD, 32'hABCD_0001);
        emu_op(RD, 32'hABCD_0000);
        emu_op(RD, 32'hABCD_0002);
        for (int n = 0; n < 20; n++) emu_op(legal[$urandom_range(0, 3)], $urandom);
        @(negedge clk);
        chk("emu_rd_count", em_rd_count, ECW'(em_n_rd));
        chk("emu_wr_count", em_wr_count, ECW'(em_n_wr));
        chk("emu_tmo_count", em_tmo_count, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
